// File: rtl/sevenseg_pkg.sv
// Shared types, constants and the leading-zero mask helper for the seven-segment scan controller.
package sevenseg_pkg;

  typedef enum logic {BLANK = 1'b0, ON = 1'b1} slot_state_e;

  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGITS = 8;
  localparam int LZ_W       = MAX_DIGITS * DIGIT_W;

  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

  // Clears enable bits of zero digits above the most significant non-zero one; digit 0 always stays.
  function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [LZ_W-1:0] val, input int ndig);
    logic lead;
    lz_mask = '1;
    lead    = 1'b1;
    for (int i = MAX_DIGITS - 1; i > 0; i--) begin
      if (i < ndig) begin
        if (lead && (val[i*DIGIT_W +: DIGIT_W] == '0)) lz_mask[i] = 1'b0;
        else lead = 1'b0;
      end
    end
  endfunction

endpackage

// File: rtl/sevenseg_slot_timer.sv
// Slot counter and digit index for the scan; exposes next-cycle phase/index so outputs can be registered.
module sevenseg_slot_timer
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_TICKS = 2,
  parameter int IDX_W       = $clog2(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [IDX_W-1:0] idx_nxt,
  output logic             on_nxt,
  output logic             frame_end
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]    CNT_LAST      = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]    CNT_BLANK_END = CW'(BLANK_TICKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(NUM_DIGITS - 1);

  slot_state_e      state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [IDX_W-1:0] idx, idx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      BLANK:   if (cnt == CNT_BLANK_END) state_d = ON;
      ON:      if (cnt == CNT_LAST) state_d = BLANK;
      default: state_d = BLANK;
    endcase

    cnt_d = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);

    idx_d = idx;
    if ((state == ON) && (cnt == CNT_LAST))
      idx_d = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
  end

  always_comb begin
    idx_nxt   = idx_d;
    on_nxt    = (state_d == ON);
    frame_end = (state == ON) && (cnt == CNT_LAST) && (idx == IDX_LAST);
  end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-aligned commit and load/ack handshake.
// Optional leading-zero blanking when SEVENSEG_BLANK_LEADING_ZERO_EN is defined.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_TICKS = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  output logic                          ack,
  output logic [DIGIT_W-1:0]            num,
  output logic [NUM_DIGITS-1:0]         an,
  output logic                          frame_tick
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int VW    = DIGIT_W * NUM_DIGITS;

  logic [VW-1:0]         comm_val, comm_val_d, pend_val, src_val;
  logic [NUM_DIGITS-1:0] comm_en, comm_en_d, pend_en, src_en, masked_en;
  logic                  pend_valid, commit_now;
  logic [IDX_W-1:0]      idx_nxt;
  logic                  on_nxt, frame_end;
  logic [DIGIT_W-1:0]    num_d;
  logic [NUM_DIGITS-1:0] an_d;
`ifdef SEVENSEG_BLANK_LEADING_ZERO_EN
  logic [MAX_DIGITS-1:0] lz;
`endif

  sevenseg_slot_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .REFRESH_DIV(REFRESH_DIV),
    .BLANK_TICKS(BLANK_TICKS),
    .IDX_W      (IDX_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .idx_nxt  (idx_nxt),
    .on_nxt   (on_nxt),
    .frame_end(frame_end)
  );

  // A load coinciding with frame end bypasses pending and is committed directly.
  always_comb begin
    src_val = load ? value : pend_val;
    src_en  = load ? digit_en : pend_en;
`ifdef SEVENSEG_BLANK_LEADING_ZERO_EN
    lz        = lz_mask(LZ_W'(src_val), NUM_DIGITS);
    masked_en = src_en & lz[NUM_DIGITS-1:0];
`else
    masked_en = src_en;
`endif
    commit_now = frame_end && (load || pend_valid);
    comm_val_d = commit_now ? src_val : comm_val;
    comm_en_d  = commit_now ? masked_en : comm_en;

    num_d = comm_val_d[idx_nxt*DIGIT_W +: DIGIT_W];
    an_d  = ANODE_OFF[NUM_DIGITS-1:0];
    if (on_nxt && comm_en_d[idx_nxt]) an_d[idx_nxt] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      comm_val   <= '0;
      comm_en    <= '0;
      pend_val   <= '0;
      pend_en    <= '0;
      pend_valid <= 1'b0;
      ack        <= 1'b0;
      frame_tick <= 1'b0;
      num        <= '0;
      an         <= ANODE_OFF[NUM_DIGITS-1:0];
    end else begin
      comm_val   <= comm_val_d;
      comm_en    <= comm_en_d;
      ack        <= commit_now;
      frame_tick <= frame_end;
      num        <= num_d;
      an         <= an_d;
      if (load && !frame_end) begin
        pend_val   <= value;
        pend_en    <= digit_en;
        pend_valid <= 1'b1;
      end else if (commit_now) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl: behavioural frame model checked every cycle plus literal frame checks.
module tb_sevenseg_scan_ctrl;

  localparam int N = 4;
  localparam int R = 4;
  localparam int B = 1;
  localparam int P = N * R;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  digit_en = '0;
  logic        ack, frame_tick;
  logic [3:0]  num;
  logic [3:0]  an;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sevenseg_scan_ctrl #(
    .NUM_DIGITS (N),
    .REFRESH_DIV(R),
    .BLANK_TICKS(B)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .value     (value),
    .digit_en  (digit_en),
    .ack       (ack),
    .num       (num),
    .an        (an),
    .frame_tick(frame_tick)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Visible digits: everything up to the most significant non-zero nibble (digit 0 always).
  function automatic logic [3:0] vis_mask(input logic [15:0] v);
`ifdef SEVENSEG_BLANK_LEADING_ZERO_EN
    int top;
    logic [3:0] m;
    top = 0;
    for (int i = 0; i < N; i++) if (v[4*i +: 4] != 4'h0) top = i;
    m = '0;
    for (int i = 0; i < N; i++) m[i] = (i <= top);
    return m;
`else
    return 4'hF;
`endif
  endfunction

  // Model: k = cycles since reset release; slot/digit follow from k by plain arithmetic.
  int          k;
  logic [15:0] m_val, p_val;
  logic [3:0]  m_en, p_en;
  logic        p_valid, e_ack, e_ft;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k <= 0; m_val <= '0; m_en <= '0; p_val <= '0; p_en <= '0;
      p_valid <= 1'b0; e_ack <= 1'b0; e_ft <= 1'b0;
    end else begin
      if (((k % P) == P - 1) && (load || p_valid)) begin
        m_val   <= load ? value : p_val;
        m_en    <= load ? (digit_en & vis_mask(value)) : (p_en & vis_mask(p_val));
        p_valid <= 1'b0;
        e_ack   <= 1'b1;
      end else begin
        e_ack <= 1'b0;
        if (load) begin
          p_val <= value; p_en <= digit_en; p_valid <= 1'b1;
        end
      end
      e_ft <= ((k % P) == P - 1);
      k    <= k + 1;
    end
  end

  task automatic compare_now();
    int s, c;
    logic [3:0] ea;
    s  = (k / R) % N;
    c  = k % R;
    ea = 4'hF;
    if (c >= B && m_en[s]) ea[s] = 1'b0;
    chk("model_an", 32'(an), 32'(ea));
    chk("model_num", 32'(num), 32'(m_val[4*s +: 4]));
    chk("model_ack", 32'(ack), 32'(e_ack));
    chk("model_ft", 32'(frame_tick), 32'(e_ft));
  endtask

  always @(negedge clk) compare_now();

  task automatic do_load(input logic [15:0] v, input logic [3:0] e);
    load = 1'b1; value = v; digit_en = e;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_sig(input string name, input bit want_ack, input int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if ((want_ack ? ack : frame_tick) === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  // Literal expectations for one full frame starting at the first blank cycle of digit 0.
  task automatic check_frame(input string name, input logic [15:0] v, input logic [3:0] lit);
    logic [3:0] ea;
    for (int j = 0; j < P; j++) begin
      int s;
      s  = j / R;
      ea = 4'hF;
      if ((j % R) >= B && lit[s]) ea[s] = 1'b0;
      chk({name, "_num"}, 32'(num), 32'(v[4*s +: 4]));
      chk({name, "_an"}, 32'(an), 32'(ea));
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ft_cnt, acks, n;
    bit saw_a;

    #1 rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_num", 32'(num), 32'h0);
      chk("rst_ack", 32'(ack), 32'h0);
      chk("rst_ft", 32'(frame_tick), 32'h0);
    end
    rst = 1'b0;

    // Dark display after reset, frame_tick every P clocks
    ft_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (frame_tick) ft_cnt++;
      chk("t1_an_dark", 32'(an), 32'hF);
    end
    chk("t1_ft_count", 32'(ft_cnt), 32'd2);

    // Mid-frame load, ack with the next frame tick, then 1234 scanned
    do_load(16'h1234, 4'hF);
    wait_sig("t2_ack_seen", 1'b1, 2 * P);
    chk("t2_ft_with_ack", 32'(frame_tick), 32'd1);
    check_frame("t2", 16'h1234, 4'hF);

    // Two loads in one frame: single ack, last value wins
    repeat (2) @(negedge clk);
    do_load(16'hAAAA, 4'hF);
    repeat (3) @(negedge clk);
    do_load(16'hBEEF, 4'hF);
    acks = 0; saw_a = 1'b0;
    repeat (24) begin
      @(negedge clk);
      if (ack) acks++;
      if (num == 4'hA) saw_a = 1'b1;
    end
    chk("t3_single_ack", 32'(acks), 32'd1);
    chk("t3_no_aaaa", 32'(saw_a), 32'd0);

    // Load exactly on the frame-end cycle
    wait_sig("t4_sync_ft", 1'b0, 2 * P);
    repeat (P - 1) @(negedge clk);
    load = 1'b1; value = 16'h5678; digit_en = 4'hF;
    @(negedge clk);
    load = 1'b0;
    chk("t4_ack", 32'(ack), 32'd1);
    chk("t4_ft", 32'(frame_tick), 32'd1);
    check_frame("t4", 16'h5678, 4'hF);

    // Reset mid-ON with a pending value
    do_load(16'h9ABC, 4'hF);
    @(negedge clk);
    chk("t5_pre_an", 32'(an), 32'h0000000E);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_an", 32'(an), 32'hF);
    chk("t5_async_num", 32'(num), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0; acks = 0;
    for (int i = 0; i < 3 * P; i++) begin
      @(negedge clk);
      n++;
      if (ack) acks++;
      if (frame_tick) break;
    end
    chk("t5_first_ft_delay", 32'(n), 32'(P));
    repeat (2 * P) begin
      @(negedge clk);
      if (ack) acks++;
    end
    chk("t5_no_ack", 32'(acks), 32'd0);

    // Randomized loads against the model
    repeat (400) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) begin
        load = 1'b1; value = 16'($urandom); digit_en = 4'($urandom);
      end else begin
        load = 1'b0;
      end
    end
    @(negedge clk);
    load = 1'b0;

    // Leading-zero handling
    wait_sig("t6_sync_ft", 1'b0, 2 * P);
    do_load(16'h0040, 4'hF);
    wait_sig("t6_ack_seen", 1'b1, 2 * P);
`ifdef SEVENSEG_BLANK_LEADING_ZERO_EN
    check_frame("t6", 16'h0040, 4'b0011);
`else
    check_frame("t6", 16'h0040, 4'b1111);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
